// File: rtl/divider_guideir_pkg.sv
// Shared types and constants for the divider stream front/back-end.
// Holds the controller state encoding, the default watchdog depth and the saturation value.
package divider_guideir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    localparam int MAX_W = 64;

    // Quotient reported on saturation or abort, sliced down to WIDTH by users.
    localparam logic [MAX_W-1:0] SAT_ONES = '1;

    function automatic int default_timeout(input int width);
        return 4 * width;
    endfunction

endpackage

// File: rtl/div_watchdog.sv
// Cycle counter for the WAIT state of the divider controller.
// Clears whenever run_i is low and flags expired_o on its TIMEOUT-th running cycle.
module div_watchdog #(
    parameter int TIMEOUT = 128
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || !run_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired_o = run_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/divider_stream_ctrl.sv
// Valid/ready wrapper around the sequential divider: issues one start per operand pair,
// holds operands through the calculation, and returns results with a tag and a watchdog abort.
module divider_stream_ctrl
    import divider_guideir_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int TAG_W       = 8,
    parameter int TIMEOUT     = default_timeout(WIDTH),
    parameter bit SAT_ON_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_dividend,
    input  logic [WIDTH-1:0] s_divisor,
    input  logic [TAG_W-1:0] s_tag,
    output logic             div_start,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder,
    input  logic             div_zero_err,
    input  logic             div_valid,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_quotient,
    output logic [WIDTH-1:0] m_remainder,
    output logic [TAG_W-1:0] m_tag,
    output logic             m_zero_err,
    output logic             m_timeout,
    output logic             busy
);

    localparam logic [WIDTH-1:0] QSAT = SAT_ONES[WIDTH-1:0];

    state_t           state_q;
    logic             s_ready_q, div_start_q, m_valid_q, busy_q;
    logic             m_zero_err_q, m_timeout_q;
    logic [WIDTH-1:0] dividend_q, divisor_q, m_quotient_q, m_remainder_q;
    logic [TAG_W-1:0] tag_q;
    logic             expired;

    div_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .run_i     (state_q == ST_WAIT),
        .expired_o (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            s_ready_q     <= 1'b1;
            div_start_q   <= 1'b0;
            m_valid_q     <= 1'b0;
            busy_q        <= 1'b0;
            m_zero_err_q  <= 1'b0;
            m_timeout_q   <= 1'b0;
            dividend_q    <= '0;
            divisor_q     <= '0;
            m_quotient_q  <= '0;
            m_remainder_q <= '0;
            tag_q         <= '0;
        end else begin
            div_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (s_valid) begin
                        dividend_q  <= s_dividend;
                        divisor_q   <= s_divisor;
                        tag_q       <= s_tag;
                        s_ready_q   <= 1'b0;
                        busy_q      <= 1'b1;
                        div_start_q <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: state_q <= ST_WAIT;
                ST_WAIT: begin
                    // A real completion wins over a watchdog expiry in the same cycle.
                    if (div_valid) begin
                        m_quotient_q  <= (div_zero_err && SAT_ON_ZERO) ? QSAT : div_quotient;
                        m_remainder_q <= div_remainder;
                        m_zero_err_q  <= div_zero_err;
                        m_timeout_q   <= 1'b0;
                        m_valid_q     <= 1'b1;
                        state_q       <= ST_OUT;
                    end else if (expired) begin
                        m_quotient_q  <= QSAT;
                        m_remainder_q <= '0;
                        m_zero_err_q  <= 1'b0;
                        m_timeout_q   <= 1'b1;
                        m_valid_q     <= 1'b1;
                        state_q       <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign s_ready      = s_ready_q;
    assign div_start    = div_start_q;
    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;
    assign m_valid      = m_valid_q;
    assign m_quotient   = m_quotient_q;
    assign m_remainder  = m_remainder_q;
    assign m_tag        = tag_q;
    assign m_zero_err   = m_zero_err_q;
    assign m_timeout    = m_timeout_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_divider_stream_ctrl.sv
// Directed plus randomized bench for divider_stream_ctrl with a behavioural divider stand-in.
module tb_divider_stream_ctrl;

    localparam int W  = 32;
    localparam int TW = 8;
    localparam int TO = 4 * W;
    localparam logic [W-1:0] ZQ = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          s_valid = 1'b0, m_ready = 1'b0;
    logic [W-1:0]  s_dividend = '0, s_divisor = '0;
    logic [TW-1:0] s_tag = '0;
    logic          s_ready, div_start, m_valid, m_zero_err, m_timeout, busy;
    logic [W-1:0]  div_dividend, div_divisor, m_quotient, m_remainder;
    logic [TW-1:0] m_tag;
    logic [W-1:0]  div_quotient, div_remainder;
    logic          div_zero_err, div_valid;

    // second instance without saturation, same stimulus
    logic          d0_s_ready, d0_start, d0_m_valid, d0_zerr, d0_to, d0_busy;
    logic [W-1:0]  d0_dd, d0_dv, d0_q, d0_r;
    logic [TW-1:0] d0_tag;

    divider_stream_ctrl #(.WIDTH(W), .TAG_W(TW), .SAT_ON_ZERO(1'b1)) u_dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_dividend(s_dividend), .s_divisor(s_divisor), .s_tag(s_tag),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .div_zero_err(div_zero_err), .div_valid(div_valid),
        .m_valid(m_valid), .m_ready(m_ready), .m_quotient(m_quotient),
        .m_remainder(m_remainder), .m_tag(m_tag), .m_zero_err(m_zero_err),
        .m_timeout(m_timeout), .busy(busy));

    divider_stream_ctrl #(.WIDTH(W), .TAG_W(TW), .SAT_ON_ZERO(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(d0_s_ready),
        .s_dividend(s_dividend), .s_divisor(s_divisor), .s_tag(s_tag),
        .div_start(d0_start), .div_dividend(d0_dd), .div_divisor(d0_dv),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .div_zero_err(div_zero_err), .div_valid(div_valid),
        .m_valid(d0_m_valid), .m_ready(m_ready), .m_quotient(d0_q),
        .m_remainder(d0_r), .m_tag(d0_tag), .m_zero_err(d0_zerr),
        .m_timeout(d0_to), .busy(d0_busy));

    // Divider stand-in: latency lat_cfg after start, immediate on zero divisor or repeated operands.
    int           lat_cfg = 1;
    bit           hang_cfg = 1'b0;
    logic         mdl_pend, last_v;
    int           mdl_cnt;
    logic [W-1:0] mdl_a, mdl_b, last_a, last_b;

    assign div_valid = mdl_pend && (mdl_cnt == 0);
    always_comb begin
        div_zero_err  = (mdl_b == '0);
        div_remainder = mdl_a;
        div_quotient  = ZQ;
        if (mdl_b != '0) begin
            div_quotient  = mdl_a / mdl_b;
            div_remainder = mdl_a % mdl_b;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            mdl_pend <= 1'b0; last_v <= 1'b0; mdl_cnt <= 0;
            mdl_a <= '0; mdl_b <= '0; last_a <= '0; last_b <= '0;
        end else if (div_start) begin
            mdl_pend <= !hang_cfg;
            mdl_a    <= div_dividend;
            mdl_b    <= div_divisor;
            mdl_cnt  <= (div_divisor == '0 || (last_v && last_a == div_dividend && last_b == div_divisor)) ? 0 : lat_cfg;
        end else if (div_valid) begin
            mdl_pend <= 1'b0; last_v <= 1'b1; last_a <= mdl_a; last_b <= mdl_b;
        end else if (mdl_pend && mdl_cnt > 0) begin
            mdl_cnt <= mdl_cnt - 1;
        end
    end

    int n_acc = 0, n_starts = 0;
    always @(posedge clk) begin
        if (!rst) begin
            if (s_valid && s_ready) n_acc++;
            if (div_start) n_starts++;
        end
    end

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference bookkeeping for the divider's one-entry result cache.
    bit           ref_v = 1'b0;
    logic [W-1:0] ref_a = '0, ref_b = '0;

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] tag,
                         input int lat, input bit hang, input int hold);
        logic [W-1:0] eq, eq0, er;
        bit ez, eto, hit, stable, held;
        int erise, rise, cyc, st0;
        hit = ref_v && ref_a == a && ref_b == b;
        if (hang) begin
            eq = '1; eq0 = '1; er = '0; ez = 0; eto = 1; erise = TO + 2;
        end else begin
            eto = 0; ez = (b == 0);
            erise = (b == 0 || hit) ? 3 : 3 + lat;
            if (b == 0) begin eq = '1; eq0 = ZQ; er = a; end
            else begin eq = a / b; eq0 = eq; er = a % b; end
            ref_v = 1; ref_a = a; ref_b = b;
        end
        lat_cfg = lat; hang_cfg = hang; m_ready = (hold == 0);
        s_valid = 1'b1; s_dividend = a; s_divisor = b; s_tag = tag;
        @(negedge clk);
        s_valid = 1'b0; s_dividend = $urandom; s_divisor = $urandom; s_tag = TW'($urandom);
        cyc = 1; rise = -1; stable = 1;
        chk("issue_start", div_start, 1'b1);
        chk("issue_sready", s_ready, 1'b0);
        while (cyc < TO + 10) begin
            if (div_dividend !== a || div_divisor !== b) stable = 0;
            if (m_valid) begin rise = cyc; break; end
            @(negedge clk); cyc++;
        end
        chk("rise_cycle", 64'(rise), 64'(erise));
        chk("quotient", m_quotient, eq);
        chk("quotient_nosat", d0_q, eq0);
        chk("remainder", m_remainder, er);
        chk("zero_err", m_zero_err, ez);
        chk("timeout", m_timeout, eto);
        chk("tag", m_tag, tag);
        held = 1; st0 = n_starts;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!m_valid || m_quotient !== eq || m_remainder !== er || m_tag !== tag ||
                s_ready || busy !== 1'b1 || div_dividend !== a || div_divisor !== b) held = 0;
        end
        if (hold > 0) begin
            chk("out_hold_stable", held, 1'b1);
            chk("out_hold_nostart", 64'(n_starts), 64'(st0));
        end
        chk("operands_stable", stable, 1'b1);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        chk("post_mvalid", m_valid, 1'b0);
        chk("post_sready", s_ready, 1'b1);
        chk("post_busy", busy, 1'b0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        repeat (2) @(negedge clk);
        chk("rst_sready", s_ready, 1'b1);
        chk("rst_start", div_start, 1'b0);
        chk("rst_mvalid", m_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_payload", {m_quotient, m_remainder}, 64'd0);
        chk("rst_ops", {div_dividend, div_divisor}, 64'd0);
        chk("rst_flags", {m_zero_err, m_timeout, m_tag}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(32'd100, 32'd7, 8'h5A, 10, 0, 0);
        do_op(32'd55, 32'd0, 8'h11, 20, 0, 0);
        do_op(32'd1000, 32'd3, 8'h21, 12, 0, 0);
        do_op(32'd1000, 32'd3, 8'h22, 30, 0, 2);
        do_op(32'd9, 32'd4, 8'h44, 5, 1, 1);
        do_op(32'd77, 32'd5, 8'h33, 5, 0, 10);

        // reset while waiting on the divider
        lat_cfg = 40; hang_cfg = 0;
        s_valid = 1'b1; s_dividend = 32'd123; s_divisor = 32'd4; s_tag = 8'h66;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("wait_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_mvalid", m_valid, 1'b0);
        chk("midrst_start", div_start, 1'b0);
        chk("midrst_sready", s_ready, 1'b1);
        rst = 1'b0; ref_v = 0;
        do_op(32'hFFFF_FFFF, 32'd1, 8'h77, 8, 0, 0);

        for (int i = 0; i < 600; i++) begin
            int sel;
            sel = $urandom_range(0, 7);
            ra = $urandom; rb = $urandom >> $urandom_range(0, 31);
            if (sel == 0) rb = '0;
            if (sel == 1 && ref_v) begin ra = ref_a; rb = ref_b; end
            do_op(ra, rb, TW'($urandom), $urandom_range(1, 2 * W), 0, $urandom_range(0, 3));
        end

        chk("starts_per_accept", 64'(n_starts), 64'(n_acc));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
